// File: rtl/dac_sched_pkg.sv
// rtl/dac_sched_pkg.sv - shared types and helpers for the DAC round-robin scheduler
package dac_sched_pkg;

    localparam int DAC_DW = 12;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        WAIT_LO = 3'd2,
        WAIT_HI = 3'd3,
        GAP     = 3'd4
    } state_t;

    function automatic int chan_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dac_sched_rr_arb.sv
// rtl/dac_sched_rr_arb.sv - combinational round-robin pick starting after the last grant
module rr_arb
    import dac_sched_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CW  = chan_w(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [CW-1:0]  ptr,
    output logic [NCH-1:0] grant,
    output logic [CW-1:0]  idx,
    output logic           any
);

    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 1; i <= NCH; i++) begin
            j = int'(ptr) + i;
            if (j >= NCH) j = j - NCH;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = CW'(j);
            end
        end
    end

endmodule

// File: rtl/dac_sched.sv
// rtl/dac_sched.sv - shares one serial DAC driver between NCH requesters; optional DAC_SCHED_REFRESH_EN
module dac_sched
    import dac_sched_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int DW      = DAC_DW,
    parameter int TO_CYC  = 16,
    parameter int GAP_CYC = 2
`ifdef DAC_SCHED_REFRESH_EN
    ,
    parameter int REFRESH_CYC = 1024
`endif
) (
    input  logic                     clk,
    input  logic                     NRST,
    input  logic [NCH-1:0]           req,
    input  logic [NCH*DW-1:0]        din,
    output logic [NCH-1:0]           ack,
    output logic [NCH-1:0]           done,
    output logic                     busy,
    output logic                     err,
    output logic [DW-1:0]            dac_di,
    output logic                     dac_st,
    input  logic                     dac_ncs,
    output logic [chan_w(NCH)-1:0]   chan
`ifdef DAC_SCHED_REFRESH_EN
    ,
    output logic                     refresh
`endif
);

    localparam int CW = chan_w(NCH);
    localparam int TW = $clog2(TO_CYC + 1);
    localparam int GW = $clog2(GAP_CYC + 2);
    localparam logic [TW-1:0] TO_LAST  = TW'(TO_CYC - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    state_t         state;
    logic [CW-1:0]  ptr;
    logic [TW-1:0]  cnt;
    logic [GW-1:0]  gcnt;
    logic [NCH-1:0] g_oh;
    logic [CW-1:0]  g_idx;
    logic           g_any;
    logic           gap_end;
    logic           ref_go;
    logic           refr;
    logic [DW-1:0]  ref_word;
    logic [CW-1:0]  ref_chan;

    rr_arb #(.NCH(NCH), .CW(CW)) u_arb (
        .req   (req),
        .ptr   (ptr),
        .grant (g_oh),
        .idx   (g_idx),
        .any   (g_any)
    );

    assign busy    = (state != IDLE);
    assign gap_end = (state == GAP) && (gcnt == GAP_LAST);

`ifdef DAC_SCHED_REFRESH_EN
    localparam int RW = $clog2(REFRESH_CYC + 1);
    localparam logic [RW-1:0] RF_LAST = RW'(REFRESH_CYC - 1);

    logic [DW-1:0] shadow [NCH];
    logic [RW-1:0] icnt;
    logic [CW-1:0] rptr;
    logic          rf;

    // Refresh walks the channels in its own RR order so it never disturbs request fairness.
    assign ref_chan = (rptr == CW'(NCH - 1)) ? '0 : rptr + 1'b1;
    assign ref_word = shadow[ref_chan];
    assign ref_go   = (state == IDLE) && !g_any && (icnt == RF_LAST);
    assign refr     = rf;
    assign refresh  = rf;

    always_ff @(posedge clk or negedge NRST) begin
        if (!NRST) begin
            icnt <= '0;
            rptr <= CW'(NCH - 1);
            rf   <= 1'b0;
            for (int i = 0; i < NCH; i++) shadow[i] <= '0;
        end else begin
            if (|req)
                icnt <= '0;
            else if (state == IDLE)
                icnt <= ref_go ? '0 : icnt + 1'b1;
            if (state == IDLE && g_any)
                shadow[g_idx] <= din[int'(g_idx)*DW +: DW];
            if (ref_go) begin
                rf   <= 1'b1;
                rptr <= ref_chan;
            end else if (gap_end) begin
                rf <= 1'b0;
            end
        end
    end
`else
    assign ref_go   = 1'b0;
    assign refr     = 1'b0;
    assign ref_word = '0;
    assign ref_chan = '0;
`endif

    always_ff @(posedge clk or negedge NRST) begin
        if (!NRST) begin
            state  <= IDLE;
            ack    <= '0;
            done   <= '0;
            dac_st <= 1'b0;
            err    <= 1'b0;
            dac_di <= '0;
            chan   <= '0;
            ptr    <= CW'(NCH - 1);
            cnt    <= '0;
            gcnt   <= '0;
        end else begin
            ack    <= '0;
            done   <= '0;
            dac_st <= 1'b0;
            case (state)
                IDLE: begin
                    if (g_any) begin
                        ack    <= g_oh;
                        dac_di <= din[int'(g_idx)*DW +: DW];
                        chan   <= g_idx;
                        ptr    <= g_idx;
                        state  <= START;
                    end else if (ref_go) begin
                        dac_di <= ref_word;
                        chan   <= ref_chan;
                        state  <= START;
                    end
                end
                START: begin
                    dac_st <= 1'b1;
                    cnt    <= '0;
                    state  <= WAIT_LO;
                end
                WAIT_LO: begin
                    if (!dac_ncs) begin
                        state <= WAIT_HI;
                    end else if (cnt == TO_LAST) begin
                        err   <= 1'b1;
                        gcnt  <= '0;
                        state <= GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_HI: begin
                    // Frame length belongs to the serializer, so no timeout while NCS is low.
                    if (dac_ncs) begin
                        done[chan] <= !refr;
                        gcnt       <= '0;
                        state      <= GAP;
                    end
                end
                GAP: begin
                    if (gap_end)
                        state <= IDLE;
                    else
                        gcnt <= gcnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dac_sched.md
Name: dac_sched

Overview:
- Round-robin scheduler that shares one serial DAC driver (12-bit word, st-pulse start, NCS frame strobe) between NCH requesters.
- Latches a requester's word and pulses the driver start, then tracks the frame via the driver's NCS and reports completion per channel.
- Sits between the channel producers and the DAC serializer; the serializer itself is unchanged.

Parameters:
- NCH, 4, number of requesting channels (2..8)
- DW, 12, DAC word width
- TO_CYC, 16, max clk cycles from dac_st to NCS falling before timeout
- GAP_CYC, 2, idle clk cycles enforced after NCS rises before the next start
- REFRESH_CYC, 1024, idle cycles before an automatic refresh (only with the optional feature)

Ports:
- clk  in  1  system clock, all logic on posedge
- NRST  in  1  asynchronous active-low reset
- req  in  NCH  per-channel request, level; data must be stable while high
- din  in  NCH*DW  channel words, channel i at [i*DW +: DW]
- ack  out  NCH  one-cycle pulse: word of channel i latched
- done  out  NCH  one-cycle pulse: frame of channel i finished (NCS rose)
- busy  out  1  high in every state except IDLE
- err  out  1  sticky timeout flag, cleared only by NRST
- dac_di  out  DW  word to serializer, held stable for the whole frame
- dac_st  out  1  one-cycle start pulse to serializer
- dac_ncs  in  1  serializer chip select (1 = idle)
- chan  out  $clog2(NCH)  channel being serviced, valid while busy

Behaviour:
- Reset (NRST=0, async):
  - state=IDLE; ack=0, done=0, dac_st=0, busy=0, err=0, dac_di=0, chan=0.
  - RR pointer=NCH-1, so channel 0 has the highest priority first.
- IDLE: when any req is high, grant the first requester searching from pointer+1 with wrap-around. In the same edge:
  - latch din slice into dac_di;
  - chan=grant, pointer=grant;
  - pulse ack[grant];
  - go to START.
- START: dac_st=1 for exactly one cycle, then go to WAIT_LO with timeout counter=0.
- WAIT_LO: wait for dac_ncs==0 and go to WAIT_HI. If the counter reaches TO_CYC first: set err, pulse nothing, go to GAP.
- WAIT_HI: wait for dac_ncs==1, then pulse done[chan] and go to GAP. No timeout here; the frame length is owned by the serializer.
- GAP: count GAP_CYC cycles, then go to IDLE. GAP_CYC=0 means a single pass-through cycle.
- Latency: req high in IDLE gives ack at edge +1, dac_st at edge +2. Back-to-back grants are separated by frame + GAP_CYC + 2 cycles.
- Arbitration:
  - req is sampled only in IDLE.
  - req deasserting while busy does not abort the frame.
  - A requester holding req high after ack gets a new grant only after every other pending requester has been served.
- dac_di and chan change only on a grant edge.
- dac_ncs falling while in IDLE/GAP (spurious) is ignored.
- NRST mid-frame: the block returns to IDLE immediately and no done is issued. The serializer frame may still complete; it is ignored because the scheduler is in IDLE.

Optional Feature:
- Macro DAC_SCHED_REFRESH_EN.
- Defined:
  - Per-channel shadow registers (reset 0) are updated on every grant.
  - An idle counter runs while in IDLE with no req and clears on any req.
  - At REFRESH_CYC the counter re-sends the shadow of the next channel in RR order through START..GAP, with no ack and no done.
  - Adds output refresh (1 bit, high while a refresh frame is busy).
  - A real req arriving during a refresh waits for IDLE.
- Undefined: no shadow registers, no counter, no refresh port; behaviour exactly as above.

Decomposition:
- Package dac_sched_pkg:
  - state encoding (IDLE, START, WAIT_LO, WAIT_HI, GAP);
  - DW default;
  - channel-index width helper.
- One sub-module rr_arb:
  - inputs NCH-bit req, pointer;
  - outputs one-hot grant, encoded index, any;
  - purely combinational priority rotate.

Test Plan:
- Single request: req=0001, din[0]=12'hA5C, dac_ncs low 2 cycles after st for 48 cycles -> ack[0] at +1, dac_st at +2, dac_di=A5C, done[0] one cycle after NCS rises, busy drops after GAP_CYC.
- RR fairness: req=1111 held with different words -> grant order 0,1,2,3,0, each ack one cycle, dac_di matches the granted channel.
- Timeout: req[2]=1, dac_ncs stays 1 -> err set after 16 cycles in WAIT_LO, no done[2], return to IDLE, err stays 1 across later good frames.
- Async reset mid-frame: NRST low during WAIT_HI -> all outputs 0 immediately; after release, req[3] wins before 0 only if 0 is idle (pointer=NCH-1).
- Simultaneous: req[1] drops the cycle after ack while req[0] rises -> frame of channel 1 completes with done[1], then channel 0 is granted.
- With DAC_SCHED_REFRESH_EN, REFRESH_CYC=64: after a write of 12'h123 to channel 0 and 64 idle cycles -> refresh=1, dac_di=123 (shadow), no ack/done.
